// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: byte-stream command parser that forwards data bytes and programs per-channel rate codes
module uart_cmd_parser #(
  parameter int          NUM_CH  = 4,
  parameter int          RATE_W  = 2,
  parameter logic [31:0] TIMEOUT = 32'd50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  output logic [NUM_CH*RATE_W-1:0] rate,
  output logic                     mode_active,
  output logic                     start,
  output logic                     cmd_err
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {NORMAL, SEL_CH, SEL_RATE} state_t;
  state_t                          state, nxt;
  logic [CH_W-1:0]                 ch;
  logic [31:0]                     idle;
  logic [NUM_CH-1:0][RATE_W-1:0]   rate_r;
  logic [7:0]                      dig;
  logic                            is_m, is_f, is_dig, tmo, fwd, bad_ch, wr_rate;
  logic [RATE_W-1:0]               code;
  assign rate = rate_r;
  // byte classification, rate code mapping and next-state selection
  always_comb begin
    dig     = rx_data - 8'h30;
    is_m    = rx_data == 8'h4D || rx_data == 8'h6D;
    is_f    = rx_data == 8'h46 || rx_data == 8'h66;
    is_dig  = dig < 8'(NUM_CH);
    tmo     = !rx_valid && state != NORMAL && idle == TIMEOUT - 32'd1;
    fwd     = rx_valid && state == NORMAL && !is_m && !is_f && rx_data != 8'h00;
    bad_ch  = rx_valid && state == SEL_CH && !is_f && !is_dig;
    wr_rate = rx_valid && state == SEL_RATE && !is_f;
    code    = rx_data == 8'h31 ? RATE_W'(0) :
              rx_data == 8'h35 ? RATE_W'(1) :
              (rx_data == 8'h41 || rx_data == 8'h61) ? RATE_W'(2) : '1;
    nxt     = !rx_valid ? (tmo ? NORMAL : state) :
              state == NORMAL ? (is_m ? SEL_CH : NORMAL) :
              is_f ? NORMAL :
              state == SEL_CH ? (is_dig ? SEL_RATE : SEL_CH) : SEL_CH;
  end
  // state, idle counter and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NORMAL;
      ch          <= '0;
      idle        <= '0;
      rate_r      <= '0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      mode_active <= 1'b0;
      start       <= 1'b1;
    end else begin
      state       <= nxt;
      mode_active <= nxt != NORMAL;
      start       <= nxt == NORMAL;
      idle        <= (rx_valid || tmo || state == NORMAL) ? '0 : idle + 32'd1;
      data_valid  <= fwd;
      cmd_err     <= tmo || bad_ch;
      if (fwd) data_out <= rx_data;
      if (rx_valid && state == SEL_CH && is_dig) ch <= dig[CH_W-1:0];
      if (wr_rate) rate_r[ch] <= code;
    end
  end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of rate channels (legal range 1..8).
REQ-002 SHALL have parameter RATE_W, default 2, the width of each channel rate code (legal range 2..4).
REQ-003 SHALL have parameter TIMEOUT, default 50000000, the idle clock cycles allowed in control mode (legal range 2..2^32-1).
REQ-004 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8 bits: received UART byte.
REQ-007 SHALL have port rx_valid, input, 1 bit: one-cycle strobe, rx_data valid.
REQ-008 SHALL have port data_out, output, 8 bits: last forwarded data byte.
REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle pulse, data_out updated.
REQ-010 SHALL have port rate, output, NUM_CH*RATE_W bits: channel k code at bits [k*RATE_W +: RATE_W].
REQ-011 SHALL have port mode_active, output, 1 bit: high while not in NORMAL.
REQ-012 SHALL have port start, output, 1 bit: the inverse of mode_active (downstream run enable).
REQ-013 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on a bad command or timeout.

Function
REQ-014 SHALL be a registered FSM with states NORMAL, SEL_CH and SEL_RATE, and SHALL act only on cycles where rx_valid=1.
REQ-015 In NORMAL, a byte of 'M' or 'm' (0x4D/0x6D) SHALL move the FSM to SEL_CH.
REQ-016 In NORMAL, 0x00, 'F' and 'f' (0x46/0x66) SHALL be ignored.
REQ-017 In NORMAL, any other byte SHALL be registered into data_out, with data_valid high for exactly the next cycle (latency 1).
REQ-018 In SEL_CH, an ASCII digit '0'..'0'+NUM_CH-1 SHALL latch the channel index and move the FSM to SEL_RATE.
REQ-019 In SEL_CH, any other non-F byte SHALL pulse cmd_err and hold SEL_CH.
REQ-020 In SEL_RATE, the byte SHALL be mapped as '1'->0, '5'->1, 'A'/'a'->2, any other non-F byte->all-ones (zero-extended from RATE_W), then written to the latched channel 1 cycle later, and the FSM SHALL return to SEL_CH.
REQ-021 In SEL_CH and SEL_RATE, 'F'/'f' SHALL return the FSM to NORMAL with no rate write; rate values SHALL persist.
REQ-022 In SEL_CH and SEL_RATE, 'M'/'m' SHALL be treated as an invalid byte (REQ-019 path in SEL_CH; all-ones rate in SEL_RATE).
REQ-023 An idle counter SHALL clear on every accepted byte and on entry to SEL_CH, and SHALL count cycles while not in NORMAL.
REQ-024 When the idle counter reaches TIMEOUT-1, the FSM SHALL go to NORMAL and pulse cmd_err.
REQ-025 If rx_valid coincides with the timeout cycle, the byte SHALL win and the counter SHALL clear.
REQ-026 Non-written channels SHALL hold their value; only one channel SHALL change per rate write.
REQ-027 mode_active and start SHALL be registered outputs derived from the next state, changing on the same edge as the state.
REQ-028 data_valid and cmd_err SHALL never be high for more than one consecutive cycle per event, and SHALL never be high together.

Reset
REQ-029 On reset low, the block SHALL asynchronously clear to state NORMAL, data_out=0x00, data_valid=0, cmd_err=0, rate=all zeros, mode_active=0, start=1, and idle counter=0.
REQ-030 Reset asserted mid-command SHALL abandon the command with no partial rate write.
REQ-031 Reset deassertion SHALL be taken on the next rising clk edge; the first byte after release SHALL be processed normally.

Verification
REQ-032 Scenario: bytes 0x41, 0x00, 0x46 in NORMAL -> data_out=0x41 with one data_valid pulse; no further pulses.
REQ-033 Scenario: 'M', '2', '5', 'F' (NUM_CH=4, RATE_W=2) -> mode_active goes high after 'M'; rate[5:4]=01; all other channels stay 00; mode_active=0 and start=1 after 'F'.
REQ-034 Scenario: 'm', '9' -> one cmd_err pulse; state remains SEL_CH; rate unchanged.
REQ-035 Scenario: 'M', '0', 'x' -> rate[1:0]=11; then 'a' is taken as a channel byte, giving a cmd_err pulse.
REQ-036 Scenario: TIMEOUT=10, 'M' then no bytes -> cmd_err pulses 10 cycles after entry; mode_active returns to 0; rate retained.
REQ-037 Scenario: reset pulsed between 'M','1' and the rate byte -> all outputs return to reset values; the subsequent byte 0x35 is forwarded as data.
